pocket_tuner: RTL and testbench
===============================

Name: pocket_tuner

Overview:
Receive-side counterpart of the pocket synth. Listens to a 1-bit square-wave input (mic comparator or loopback from a synth audio_out) and measures the rising-edge-to-rising-edge period. It classifies the tone as one of the four synth notes (C4/E4/G4/B4) and reports a stable, debounced note indication on LEDs.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz; all note periods derive from it.
TOL_SHIFT, 5, match window is expected period ± (expected >> TOL_SHIFT), about ±3.1%.
MATCH_COUNT, 3, number of consecutive in-window periods of the same note required before lock (range 1..7).
TIMEOUT, CLK_FREQ/100, cycles without a rising edge before the input is declared silent (default 500_000).

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous, active-low reset.
audio_in  input  1  asynchronous square-wave input.
note_valid  output  1  high while a note is locked.
note_id  output  2  locked note: 0=C4, 1=E4, 2=G4, 3=B4; 0 when not valid.
leds  output  4  one-hot of note_id when note_valid, else 0.
note_change  output  1  one-cycle pulse when note_valid rises or note_id changes while valid.
period  output  24  last measured full period in clk cycles.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM IDLE, counter 0, candidate none, match_cnt 0.
- Input path: 2-flop synchronizer, then a previous-value flop. Rise detect = sync[1] & ~prev, giving 3 cycles of latency from a pin edge.
- Expected periods: EXP_k = 2*(CLK_FREQ/(2*f_k)), with integer-truncated half periods. At default CLK_FREQ: C4 190838, E4 151514, G4 127550, B4 101214.
- Windows are inclusive: EXP_k - (EXP_k>>TOL_SHIFT) <= P <= EXP_k + (EXP_k>>TOL_SHIFT). Windows are disjoint at the defaults.
- Period counter (cnt, 24 bit): cleared to 0 on every rise; otherwise increments, saturating at 2^24-1. Measured P = cnt+1, so a wave with period N cycles yields P=N.
- FSM:
  - IDLE: cnt held at 0. Rise -> ARMED. No measurement is taken.
  - ARMED: first edge seen. Rise -> latch period<=P, classify, go to TRACK. cnt==TIMEOUT-1 with no rise -> IDLE.
  - TRACK: on each rise, latch period<=P and classify:
    - In window of note k, and k==candidate: match_cnt++ (saturate at MATCH_COUNT).
    - In window of note k, and k!=candidate: candidate<=k, match_cnt<=1.
    - In no window: candidate<=none, match_cnt<=0.
  - TRACK timeout (cnt==TIMEOUT-1, no rise): -> IDLE, candidate none, match_cnt 0. period retains its value.
- Outputs are registered and updated the cycle after the rise/timeout cycle:
  - note_valid = (match_cnt>=MATCH_COUNT).
  - note_id = candidate when valid, else 0.
  - leds are derived from the registered note_valid and note_id.
- A note switch drops note_valid on the first period of the new note. It re-locks after MATCH_COUNT periods of the new note.
- Simultaneous rise and timeout in the same cycle: the rise wins.
- Saturated counter: P out of every window, so it is rejected.
- note_change: asserted for exactly 1 cycle when the registered valid goes 0->1, or when note_id changes while valid stays 1. Never asserted on 1->0.
- Reset mid-operation: immediate clear as at reset. After release, a lock requires a fresh arm edge plus MATCH_COUNT periods.

Decomposition:
- Shared package (also consumed by the synth):
  - Half-period constants HALF_C4/E4/G4/B4 as functions of CLK_FREQ.
  - Note-id encoding 0..3 plus a NONE encoding for candidate.
  - Period width 24.
  - Window-bound helper function (expected, TOL_SHIFT) -> lo/hi.
- Sub-module sync_edge_detect: 2-flop synchronizer plus rise pulse. Reusable for key inputs elsewhere.
- The FSM, classifier and outputs stay in pocket_tuner.

Test Plan:
1. Reset, audio_in held 0 for 600_000 cycles -> note_valid=0, leds=0, period=0, note_change never pulses.
2. E4 square wave (half period 75757) -> period=151514 after the 2nd rise. note_valid=1, note_id=1, leds=4'b0010 one cycle after the 4th rise; note_change high exactly 1 cycle.
3. Lock on E4, then switch to G4 (half 63775) -> note_valid drops after the first in-window G4 period. It re-locks with note_id=2, leds=4'b0100 after 3 consecutive G4 periods, with one note_change pulse.
4. Window edges for C4: period 196801 repeated -> locks note_id=0. Period 196802, and also 170000, repeated -> note_valid stays 0, period reports the measured value.
5. Lock on B4 (period 101214), then hold audio_in low -> note_valid and leds fall 500_000 cycles after the last rise (+1 cycle register). period stays 101214; the next tone needs an arm edge plus 3 periods.
6. Lock on C4, pulse rst_n low for 5 cycles mid-wave -> outputs 0 asynchronously. After release, lock returns only on the 4th post-reset rise.

Source files
------------

// File: rtl/pocket_tuner_pkg.sv
// Shared pocket synth/tuner definitions: note encoding, note frequencies,
// period width and the match-window helper.
package pocket_tuner_pkg;

    localparam int PERIOD_W = 24;

    // Integer note frequencies in Hz, shared with the synth tone generator.
    localparam int unsigned FREQ_C4 = 262;
    localparam int unsigned FREQ_E4 = 330;
    localparam int unsigned FREQ_G4 = 392;
    localparam int unsigned FREQ_B4 = 494;

    typedef logic [PERIOD_W-1:0] period_t;

    typedef enum logic [2:0] {
        NOTE_C4   = 3'd0,
        NOTE_E4   = 3'd1,
        NOTE_G4   = 3'd2,
        NOTE_B4   = 3'd3,
        NOTE_NONE = 3'd4
    } note_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_TRACK
    } tuner_state_t;

    typedef struct packed {
        period_t lo;
        period_t hi;
    } window_t;

    // Half period is truncated first so the synth and tuner agree exactly.
    function automatic period_t half_period(input int unsigned clk_freq, input int unsigned freq);
        return period_t'(clk_freq / (2 * freq));
    endfunction

    function automatic period_t half_c4(input int unsigned clk_freq);
        return half_period(clk_freq, FREQ_C4);
    endfunction

    function automatic period_t half_e4(input int unsigned clk_freq);
        return half_period(clk_freq, FREQ_E4);
    endfunction

    function automatic period_t half_g4(input int unsigned clk_freq);
        return half_period(clk_freq, FREQ_G4);
    endfunction

    function automatic period_t half_b4(input int unsigned clk_freq);
        return half_period(clk_freq, FREQ_B4);
    endfunction

    // Inclusive window: expected +/- (expected >> tol_shift).
    function automatic window_t note_window(input period_t expected, input int unsigned tol_shift);
        window_t w;
        w.lo = expected - (expected >> tol_shift);
        w.hi = expected + (expected >> tol_shift);
        return w;
    endfunction

endpackage

// File: rtl/pocket_tuner_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous pin plus a one-cycle rise pulse.
module pocket_tuner_sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [1:0] sync;
    logic       prev;

    // Synchronize the pin and keep the previous synchronized level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b00;
            prev <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            prev <= sync[1];
        end
    end

    assign rise = sync[1] & ~prev;

endmodule

// File: rtl/pocket_tuner.sv
// Square-wave note tuner: measures rise-to-rise period, classifies it as one
// of four synth notes and reports a debounced lock on LEDs.
module pocket_tuner
    import pocket_tuner_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned TOL_SHIFT   = 5,
    parameter int unsigned MATCH_COUNT = 3,
    parameter int unsigned TIMEOUT     = CLK_FREQ / 100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                audio_in,
    output logic                note_valid,
    output logic [1:0]          note_id,
    output logic [3:0]          leds,
    output logic                note_change,
    output logic [PERIOD_W-1:0] period
);

    localparam window_t WIN_C4 = note_window(half_c4(CLK_FREQ) << 1, TOL_SHIFT);
    localparam window_t WIN_E4 = note_window(half_e4(CLK_FREQ) << 1, TOL_SHIFT);
    localparam window_t WIN_G4 = note_window(half_g4(CLK_FREQ) << 1, TOL_SHIFT);
    localparam window_t WIN_B4 = note_window(half_b4(CLK_FREQ) << 1, TOL_SHIFT);

    localparam period_t    TO_LAST   = period_t'(TIMEOUT - 1);
    localparam logic [2:0] MATCH_MAX = 3'(MATCH_COUNT);

    // Windows are disjoint, so at most one test can hit.
    function automatic note_t classify(input period_t p);
        note_t n;
        n = NOTE_NONE;
        if (p >= WIN_C4.lo && p <= WIN_C4.hi) n = NOTE_C4;
        if (p >= WIN_E4.lo && p <= WIN_E4.hi) n = NOTE_E4;
        if (p >= WIN_G4.lo && p <= WIN_G4.hi) n = NOTE_G4;
        if (p >= WIN_B4.lo && p <= WIN_B4.hi) n = NOTE_B4;
        return n;
    endfunction

    logic         rise;
    tuner_state_t state, state_nxt;
    period_t      cnt, cnt_nxt, period_nxt, p_meas;
    note_t        cand, cand_nxt, hit;
    logic [2:0]   match_cnt, match_nxt;
    logic         valid_d;

    pocket_tuner_sync_edge_detect u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (audio_in),
        .rise  (rise)
    );

    // Measured period is cnt+1, pinned at full scale once cnt saturates.
    assign p_meas  = (cnt == '1) ? cnt : cnt + 1'b1;
    assign hit     = classify(p_meas);
    assign valid_d = (match_cnt >= MATCH_MAX);

    // State, counter, last period and candidate/match tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            period    <= '0;
            cand      <= NOTE_NONE;
            match_cnt <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            period    <= period_nxt;
            cand      <= cand_nxt;
            match_cnt <= match_nxt;
        end
    end

    // Next-state: arm on the first edge, measure and classify on later edges,
    // drop to IDLE when the input goes quiet (a coincident rise wins).
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = (cnt == '1) ? cnt : cnt + 1'b1;
        period_nxt = period;
        cand_nxt   = cand;
        match_nxt  = match_cnt;
        case (state)
            ST_ARMED, ST_TRACK: begin
                if (rise) begin
                    cnt_nxt    = '0;
                    period_nxt = p_meas;
                    state_nxt  = ST_TRACK;
                    if (hit == NOTE_NONE) begin
                        cand_nxt  = NOTE_NONE;
                        match_nxt = '0;
                    end else if (hit == cand) begin
                        if (match_cnt < MATCH_MAX) match_nxt = match_cnt + 3'd1;
                    end else begin
                        cand_nxt  = hit;
                        match_nxt = 3'd1;
                    end
                end else if (cnt == TO_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    cand_nxt  = NOTE_NONE;
                    match_nxt = '0;
                end
            end
            default: begin
                cnt_nxt = '0;
                if (rise) state_nxt = ST_ARMED;
            end
        endcase
    end

    // Registered lock indication and change pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_valid  <= 1'b0;
            note_id     <= 2'd0;
            note_change <= 1'b0;
        end else begin
            note_valid  <= valid_d;
            note_id     <= valid_d ? 2'(cand) : 2'd0;
            note_change <= valid_d && (!note_valid || (2'(cand) != note_id));
        end
    end

    assign leds = note_valid ? (4'b0001 << note_id) : 4'b0000;

endmodule

// File: tb/tb_pocket_tuner.sv
// Randomized and directed bench for pocket_tuner against an event-level
// model built from the note-period rules (scaled clock for short runs).
module tb_pocket_tuner;

    localparam int unsigned CF = 100_000;
    localparam int unsigned TS = 5;
    localparam int unsigned MC = 3;
    localparam int unsigned TO = CF / 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        audio_in = 1'b0;
    logic        note_valid;
    logic [1:0]  note_id;
    logic [3:0]  leds;
    logic        note_change;
    logic [23:0] period;

    pocket_tuner #(
        .CLK_FREQ    (CF),
        .TOL_SHIFT   (TS),
        .MATCH_COUNT (MC),
        .TIMEOUT     (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .audio_in    (audio_in),
        .note_valid  (note_valid),
        .note_id     (note_id),
        .leds        (leds),
        .note_change (note_change),
        .period      (period)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // note_change pulse counter and width monitor
    int   chg_cnt = 0;
    int   chg_wide = 0;
    logic chg_prev = 1'b0;
    always @(negedge clk) begin
        if (note_change === 1'b1) begin
            chg_cnt <= chg_cnt + 1;
            if (chg_prev) chg_wide <= chg_wide + 1;
        end
        chg_prev <= (note_change === 1'b1);
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int FREQ[4] = '{262, 330, 392, 494};
    int m_state = 0;   // 0 silent, 1 first edge seen, 2 measuring
    int m_cand = -1;
    int m_mcnt = 0;
    int m_period = 0;
    int m_valid = 0;
    int m_id = 0;
    int exp_chg = 0;
    int last_rise = 0;

    function automatic int expected(input int k);
        return 2 * (int'(CF) / (2 * FREQ[k]));
    endfunction

    function automatic int mclass(input int p);
        int r, e, t;
        r = -1;
        for (int k = 0; k < 4; k++) begin
            e = expected(k);
            t = e >> TS;
            if (p >= e - t && p <= e + t) r = k;
        end
        return r;
    endfunction

    task automatic model_outputs();
        int nv, nid;
        nv  = (m_mcnt >= int'(MC)) ? 1 : 0;
        nid = (nv != 0) ? m_cand : 0;
        if (nv != 0 && (m_valid == 0 || nid != m_id)) exp_chg++;
        m_valid = nv;
        m_id    = nid;
    endtask

    task automatic model_timeout();
        if (m_state != 0 && cyc - last_rise > int'(TO)) begin
            m_state = 0;
            m_cand  = -1;
            m_mcnt  = 0;
            model_outputs();
        end
    endtask

    task automatic model_rise();
        int gap, k;
        gap = cyc - last_rise;
        model_timeout();
        if (m_state == 0) begin
            m_state = 1;
        end else begin
            m_period = gap;
            k = mclass(gap);
            if (k < 0) begin
                m_cand = -1;
                m_mcnt = 0;
            end else if (k == m_cand) begin
                if (m_mcnt < int'(MC)) m_mcnt++;
            end else begin
                m_cand = k;
                m_mcnt = 1;
            end
            m_state = 2;
        end
        last_rise = cyc;
        model_outputs();
    endtask

    task automatic model_reset();
        m_state = 0; m_cand = -1; m_mcnt = 0; m_period = 0;
        m_valid = 0; m_id = 0;
    endtask

    // ---------------- checks and stimulus ----------------
    task automatic check_all(input string tag);
        logic [3:0] el;
        model_timeout();
        el = (m_valid != 0) ? (4'b0001 << m_id) : 4'b0000;
        chk({tag, ".valid"},  64'(note_valid), 64'(m_valid));
        chk({tag, ".id"},     64'(note_id),    64'(m_id));
        chk({tag, ".leds"},   64'(leds),       64'(el));
        chk({tag, ".period"}, 64'(period),     64'(m_period));
        chk({tag, ".chg"},    64'(chg_cnt),    64'(exp_chg));
    endtask

    // One full cycle of the square wave; outputs checked mid high-phase.
    task automatic send_period(input int p, input string tag);
        int hi;
        hi = p / 2;
        @(negedge clk);
        audio_in = 1'b1;
        model_rise();
        repeat (hi) @(negedge clk);
        check_all(tag);
        audio_in = 1'b0;
        repeat (p - hi - 1) @(negedge clk);
    endtask

    task automatic send_note(input int p, input int n, input string tag);
        for (int i = 0; i < n; i++) send_period(p, tag);
    endtask

    task automatic silence(input int n, input string tag);
        audio_in = 1'b0;
        repeat (n) @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        audio_in = 1'b0;
        #1;
        chk({tag, ".valid"},  64'(note_valid),  64'd0);
        chk({tag, ".id"},     64'(note_id),     64'd0);
        chk({tag, ".leds"},   64'(leds),        64'd0);
        chk({tag, ".period"}, 64'(period),      64'd0);
        chk({tag, ".pulse"},  64'(note_change), 64'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int kind, cnt, p, e, t, tries;

        // quiet input after reset
        do_reset("rst");
        silence(1200, "quiet");

        // E4 lock: arm edge plus three periods
        send_note(302, 4, "e4");
        chk("e4.period_const", 64'(period), 64'd302);
        chk("e4.leds_const",   64'(leds),   64'b0010);

        // switch to G4: drop on first G4 period, relock after three
        send_note(254, 5, "g4");
        chk("g4.leds_const", 64'(leds), 64'b0100);

        // C4 window edges (expected 380, tolerance 11)
        send_note(391, 5, "c4.hi_in");
        send_note(392, 5, "c4.hi_out");
        send_note(369, 5, "c4.lo_in");
        send_note(368, 5, "c4.lo_out");
        send_note(340, 4, "c4.off");

        // B4 lock, then silence across the timeout
        send_note(202, 5, "b4");
        silence(int'(TO) - 20 - 201, "b4.before_to");
        silence(40, "b4.after_to");
        chk("b4.period_hold", 64'(period), 64'd202);
        send_note(202, 4, "b4.relock");

        // gap exactly TIMEOUT is still measured; one more cycle times out
        send_period(1000, "to.edge_a");
        send_period(1001, "to.edge_b");
        send_note(380, 4, "to.rearm");

        // reset mid-wave, then relock from scratch
        send_note(380, 2, "c4.pre_rst");
        do_reset("rst.mid");
        send_note(380, 5, "c4.post_rst");

        // randomized note sequences, off-window periods and silences
        for (int s = 0; s < 25; s++) begin
            kind = int'($urandom_range(0, 5));
            cnt  = int'($urandom_range(1, 5));
            for (int i = 0; i < cnt; i++) begin
                if (kind < 4) begin
                    e = expected(kind);
                    t = e >> TS;
                    p = e - t + int'($urandom_range(0, 2 * t));
                end else begin
                    p = 900;
                    tries = 0;
                    do begin
                        p = int'($urandom_range(150, 950));
                        tries++;
                    end while (mclass(p) >= 0 && tries < 100);
                    if (mclass(p) >= 0) p = 900;
                end
                send_period(p, "rnd");
            end
            if ($urandom_range(0, 4) == 0) silence(1300, "rnd.quiet");
        end

        chk("chg.width", 64'(chg_wide), 64'd0);
        chk("chg.total", 64'(chg_cnt),  64'(exp_chg));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
